video_rst_gen: RTL

Reset and lock-qualification sequencer that sits directly downstream of the video PLL on the HDMI card. It drives the PLL's reset, synchronizes the PLL's asynchronous lock flag, and holds the video-domain reset until lock has been stable for a programmable interval. It also detects lock loss, retries a PLL that never locks, and counts relock events for status readback.

---
 rtl/video_rst_pkg.sv | 24 ++
 rtl/video_rst_gen_sync_2ff.sv | 30 +++
 rtl/video_rst_gen.sv | 113 +++++++++++
 3 files changed

// File: rtl/video_rst_pkg.sv
// Shared types, parameter defaults and counter sizing for the video reset sequencer.
package video_rst_pkg;

  typedef enum logic [1:0] {
    PLLRST    = 2'd0,
    WAIT_LOCK = 2'd1,
    STABLE    = 2'd2,
    RUN       = 2'd3
  } state_e;

  localparam int DEF_RST_CYCLES     = 16;
  localparam int DEF_STABLE_CYCLES  = 1024;
  localparam int DEF_TIMEOUT_CYCLES = 65536;

  // Width that holds 0..max-1 of the three intervals; never narrower than one bit.
  function automatic int cnt_width(input int a, input int b, input int c);
    int m;
    m = a;
    if (b > m) m = b;
    if (c > m) m = c;
    return (m > 1) ? $clog2(m) : 1;
  endfunction

endpackage

// File: rtl/video_rst_gen_sync_2ff.sv
// One-bit two-flop synchronizer, async active-low reset, resets to 0.
module sync_2ff (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic q
);

  logic meta_q, meta_d;
  logic sync_q, sync_d;

  always_comb begin
    meta_d = d;
    sync_d = meta_q;
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta_q <= 1'b0;
      sync_q <= 1'b0;
    end else begin
      meta_q <= meta_d;
      sync_q <= sync_d;
    end
  end

  assign q = sync_q;

endmodule

// File: rtl/video_rst_gen.sv
// PLL reset / lock-qualification sequencer. Define VIDEO_RST_TIMEOUT_EN to
// re-reset a PLL that fails to lock within TIMEOUT_CYCLES.
module video_rst_gen
  import video_rst_pkg::*;
#(
  parameter int RST_CYCLES     = DEF_RST_CYCLES,
  parameter int STABLE_CYCLES  = DEF_STABLE_CYCLES,
  parameter int TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES,
  parameter int CNT_W          = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             pll_lock,
  output logic             pll_rst,
  output logic             video_rst_n,
  output logic             pll_ready,
  output logic             lock_lost,
  output logic [CNT_W-1:0] relock_cnt
);

  localparam int CW = cnt_width(RST_CYCLES, STABLE_CYCLES, TIMEOUT_CYCLES);
  localparam logic [CW-1:0] RST_LAST    = CW'(RST_CYCLES - 1);
  localparam logic [CW-1:0] STABLE_LAST = CW'(STABLE_CYCLES - 1);
`ifdef VIDEO_RST_TIMEOUT_EN
  localparam logic [CW-1:0] TIMEOUT_LAST = CW'(TIMEOUT_CYCLES - 1);
`endif

  logic             lock_s;
  state_e           state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             pll_rst_q, pll_rst_d;
  logic             video_rst_n_q, video_rst_n_d;
  logic             pll_ready_q, pll_ready_d;
  logic             lock_lost_q, lock_lost_d;
  logic [CNT_W-1:0] relock_cnt_q, relock_cnt_d;

  sync_2ff u_lock_sync (
    .clk   (clk),
    .rst_n (rst_n),
    .d     (pll_lock),
    .q     (lock_s)
  );

  // NOTE: every always_comb output gets a default first so no path can infer a latch.
  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q + CW'(1);
    lock_lost_d  = 1'b0;
    relock_cnt_d = relock_cnt_q;

    unique case (state_q)
      PLLRST: begin
        if (cnt_q == RST_LAST) state_d = WAIT_LOCK;
      end
      WAIT_LOCK: begin
        if (lock_s) state_d = STABLE;
`ifdef VIDEO_RST_TIMEOUT_EN
        else if (cnt_q == TIMEOUT_LAST) state_d = PLLRST;
`else
        else cnt_d = cnt_q;
`endif
      end
      STABLE: begin
        // A dropout wins over a completed count: the lock must be seen through the last cycle.
        if (!lock_s) state_d = WAIT_LOCK;
        else if (cnt_q == STABLE_LAST) state_d = RUN;
      end
      RUN: begin
        cnt_d = cnt_q;
        if (!lock_s) begin
          state_d     = PLLRST;
          lock_lost_d = 1'b1;
          if (relock_cnt_q != '1) relock_cnt_d = relock_cnt_q + CNT_W'(1);
        end
      end
      default: state_d = PLLRST;
    endcase

    if (state_d != state_q) cnt_d = '0;

    // Outputs decode the next state so they switch on the same edge as the state.
    pll_rst_d     = (state_d == PLLRST);
    video_rst_n_d = (state_d == RUN);
    pll_ready_d   = (state_d == RUN);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= PLLRST;
      cnt_q         <= '0;
      pll_rst_q     <= 1'b1;
      video_rst_n_q <= 1'b0;
      pll_ready_q   <= 1'b0;
      lock_lost_q   <= 1'b0;
      relock_cnt_q  <= '0;
    end else begin
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      pll_rst_q     <= pll_rst_d;
      video_rst_n_q <= video_rst_n_d;
      pll_ready_q   <= pll_ready_d;
      lock_lost_q   <= lock_lost_d;
      relock_cnt_q  <= relock_cnt_d;
    end
  end

  assign pll_rst     = pll_rst_q;
  assign video_rst_n = video_rst_n_q;
  assign pll_ready   = pll_ready_q;
  assign lock_lost   = lock_lost_q;
  assign relock_cnt  = relock_cnt_q;

endmodule
